// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - raw level input synchronizer, debouncer and press counter
//
// Purpose:
//   Takes a raw asynchronous level, such as a push-button or switch.
//   Brings it into the clk domain through a two-flop synchronizer.
//   Accepts a level change only after STABLE_CYCLES consecutive identical
//   synchronized samples. Also counts accepted rising edges.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous active-high reset, highest priority
//   din      in   raw asynchronous level
//   cnt_clr  in   synchronous clear of evt_cnt; wins over a same-edge rise
//   dout     out  debounced level
//   rise     out  one-cycle pulse on the first cycle of dout=1
//   fall     out  one-cycle pulse on the first cycle of dout=0
//   busy     out  high while a level change is being qualified
//   evt_cnt  out  accepted rises, modulo 2^EVT_W
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CW            = 3,
    parameter int EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             cnt_clr,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [EVT_W-1:0] evt_cnt
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    // The first sample of a new level is counted on entry to a CHK_* state.
    // Reaching CNT_LAST with the level still present means STABLE_CYCLES
    // consecutive samples have been seen.
    localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

    // Synchronizer. Only s2 is allowed to influence the FSM.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    // State register: every flop of the block, with reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    // Next-state logic. Also computes the stability counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOW: begin
                if (s2_q) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_HIGH: begin
                if (!s2_q) begin
                    // Glitch: the high excursion ended before it qualified.
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s2_q) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_LOW: begin
                if (s2_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. Outputs are registered, so their next values are derived
    // from the transition being taken. Pulses fire only on a qualified
    // acceptance, never on a glitch return.
    always_comb begin
        dout_d    = (state_d == ST_HIGH) || (state_d == ST_CHK_LOW);
        busy_d    = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);
        rise_d    = (state_q == ST_CHK_HIGH) && (state_d == ST_HIGH);
        fall_d    = (state_q == ST_CHK_LOW) && (state_d == ST_LOW);
        evt_cnt_d = evt_cnt_q;
        if (cnt_clr) begin
            evt_cnt_d = '0;
        end else if (rise_d) begin
            evt_cnt_d = evt_cnt_q + EVT_ONE;
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = busy_q;
    assign evt_cnt = evt_cnt_q;

endmodule
